// File: rtl/wave_display_pkg.sv
// Shared constants and the sample scaling helper for the waveform display.
package wave_display_pkg;

  localparam logic [23:0] GRID_COLOR = 24'h404040;
  localparam logic [23:0] BLACK      = 24'h000000;
  localparam int          GRID_LOG2  = 6;

  // Shift the raw sample down, add the vertical offset, and clamp to the
  // largest value a sample_w-bit row coordinate can hold.
  function automatic logic [31:0] sat_scale(input logic [31:0] raw,
                                            input int          shift,
                                            input int          offset,
                                            input int          sample_w);
    logic [31:0] sum;
    logic [31:0] max_v;
    sum   = (raw >> shift) + 32'(offset);
    max_v = (32'd1 << sample_w) - 32'd1;
    return (sum > max_v) ? max_v : sum;
  endfunction

endpackage

// File: rtl/wave_channel.sv
// One trace: remembers the last two scaled samples and reports whether the
// current row falls on the vertical span joining them.
module wave_channel
  import wave_display_pkg::*;
#(
  parameter int SAMPLE_W     = 8,
  parameter int IDX_W        = 8,
  parameter int VSCALE_SHIFT = 1,
  parameter int VOFFSET      = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_valid,
  input  logic                line_start,
  input  logic [IDX_W-1:0]    addr,
  input  logic [SAMPLE_W-1:0] raw,
  input  logic [SAMPLE_W-1:0] y8,
  input  logic                hit_en,
  output logic                hit
);

  logic [IDX_W-1:0]    last_addr;
  logic [SAMPLE_W-1:0] prev;
  logic [SAMPLE_W-1:0] cur;
  logic [SAMPLE_W-1:0] adj;
  logic [SAMPLE_W-1:0] lo;
  logic [SAMPLE_W-1:0] hi;
  logic                capture;

  assign adj     = SAMPLE_W'(sat_scale(32'(raw), VSCALE_SHIFT, VOFFSET, SAMPLE_W));
  assign capture = sample_valid && ((addr != last_addr) || line_start);

  // Sample history; a line start seeds both entries so no span reaches back
  // to the previous line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_addr <= '0;
      prev      <= '0;
      cur       <= '0;
    end else if (capture) begin
      last_addr <= addr;
      cur       <= adj;
      prev      <= line_start ? adj : cur;
    end
  end

  assign lo  = (prev < cur) ? prev : cur;
  assign hi  = (prev < cur) ? cur : prev;
  assign hit = hit_en && (y8 >= lo) && (y8 <= hi);

endmodule

// File: rtl/wave_display_mc.sv
// Multi-channel waveform renderer: maps pixels to sample addresses, follows
// the one-cycle RAM latency and paints each channel trace over an optional grid.
// Handshake: valid qualifies x/y for a single cycle; there is no ready, the
// pipeline never stalls, and pixel_valid is valid delayed by three cycles.
module wave_display_mc
  import wave_display_pkg::*;
#(
  parameter int                    CHANNELS     = 2,
  parameter int                    SAMPLE_W     = 8,
  parameter int                    ADDR_W       = 9,
  parameter int                    X_START      = 256,
  parameter int                    Y_TOP        = 0,
  parameter int                    ZOOM_LOG2    = 1,
  parameter int                    VSCALE_SHIFT = 1,
  parameter int                    VOFFSET      = 32,
  parameter logic [24*CHANNELS-1:0] CH_COLOR    = {24'hFFFF00, 24'h00FFFF}
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [10:0]                  x,
  input  logic [9:0]                   y,
  input  logic                         valid,
  input  logic                         read_index,
  input  logic [CHANNELS*SAMPLE_W-1:0] read_value,
  input  logic                         grid_en,
  output logic [ADDR_W-1:0]            read_address,
  output logic                         pixel_valid,
  output logic                         valid_pixel,
  output logic [7:0]                   r,
  output logic [7:0]                   g,
  output logic [7:0]                   b
);

  localparam int IDX_W = ADDR_W - 1;
  localparam int YW    = SAMPLE_W + 1;
  localparam int XSPAN = 1 << (IDX_W + ZOOM_LOG2);
  localparam int YSPAN = 1 << YW;

  logic [11:0]          x_diff;
  logic [10:0]          y_diff;
  logic                 in_x;
  logic                 in_y;
  logic [IDX_W-1:0]     index;
  logic                 frame_bank;

  logic                 s1_valid;
  logic                 s1_in_win;
  logic                 s1_line_start;
  logic [IDX_W-1:0]     s1_index;
  logic [GRID_LOG2-1:0] s1_x_lo;
  logic [YW-1:0]        s1_y_rel;

  logic                 s2_valid;
  logic                 s2_in_win;
  logic [GRID_LOG2-1:0] s2_x_lo;
  logic [YW-1:0]        s2_y_rel;

  logic [CHANNELS-1:0]  hit;
  logic [23:0]          color;

  assign x_diff       = {1'b0, x} - 12'(X_START);
  assign in_x         = ({1'b0, x} >= 12'(X_START)) && (x_diff < 12'(XSPAN));
  assign y_diff       = {1'b0, y} - 11'(Y_TOP);
  assign in_y         = ({1'b0, y} >= 11'(Y_TOP)) && (y_diff < 11'(YSPAN));
  assign index        = in_x ? IDX_W'(x_diff >> ZOOM_LOG2) : '0;
  assign read_address = {frame_bank, index};

  // Bank select only moves at the first pixel of a frame, so a frame never tears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_bank <= 1'b0;
    end else if (valid && (x == 11'd0) && (y == 10'd0)) begin
      frame_bank <= read_index;
    end
  end

  // Stage 1 waits for RAM data; stage 2 lines up with the captured samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid      <= 1'b0;
      s1_in_win     <= 1'b0;
      s1_line_start <= 1'b0;
      s1_index      <= '0;
      s1_x_lo       <= '0;
      s1_y_rel      <= '0;
      s2_valid      <= 1'b0;
      s2_in_win     <= 1'b0;
      s2_x_lo       <= '0;
      s2_y_rel      <= '0;
    end else begin
      s1_valid      <= valid;
      s1_in_win     <= in_x && in_y;
      s1_line_start <= in_x && in_y && (x_diff == 12'd0);
      s1_index      <= index;
      s1_x_lo       <= x_diff[GRID_LOG2-1:0];
      s1_y_rel      <= y_diff[YW-1:0];
      s2_valid      <= s1_valid;
      s2_in_win     <= s1_in_win;
      s2_x_lo       <= s1_x_lo;
      s2_y_rel      <= s1_y_rel;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    wave_channel #(
      .SAMPLE_W     (SAMPLE_W),
      .IDX_W        (IDX_W),
      .VSCALE_SHIFT (VSCALE_SHIFT),
      .VOFFSET      (VOFFSET)
    ) u_channel (
      .clk          (clk),
      .reset        (reset),
      .sample_valid (s1_valid && s1_in_win),
      .line_start   (s1_line_start),
      .addr         (s1_index),
      .raw          (read_value[c*SAMPLE_W +: SAMPLE_W]),
      .y8           (s2_y_rel[SAMPLE_W:1]),
      .hit_en       (s2_in_win),
      .hit          (hit[c])
    );
  end

  // Colour mux: grid under everything, lowest-index hitting channel on top.
  always_comb begin
    color = BLACK;
    if (s2_in_win && grid_en &&
        ((s2_x_lo == '0) || (s2_y_rel[GRID_LOG2-1:0] == '0))) begin
      color = GRID_COLOR;
    end
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (hit[c]) color = CH_COLOR[c*24 +: 24];
    end
  end

  // Registered outputs, held black whenever the aligned pixel is not valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel_valid <= 1'b0;
      valid_pixel <= 1'b0;
      {r, g, b}   <= BLACK;
    end else begin
      pixel_valid <= s2_valid;
      valid_pixel <= s2_valid && (|hit);
      {r, g, b}   <= s2_valid ? color : BLACK;
    end
  end

endmodule

// File: tb/tb_wave_display_mc.sv
// Directed bench for wave_display_mc: one task per feature, inline checks.
module tb_wave_display_mc;

  localparam logic [23:0] C0   = 24'hFFFF00;
  localparam logic [23:0] C1   = 24'h00FFFF;
  localparam logic [23:0] GRID = 24'h404040;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] x;
  logic [9:0]  y;
  logic        valid;
  logic        read_index;
  logic        grid_en;
  logic [15:0] read_value;
  logic [8:0]  read_address;
  logic        pixel_valid;
  logic        valid_pixel;
  logic [7:0]  r, g, b;
  logic [8:0]  sat_address;
  logic        sat_pixel_valid;
  logic        sat_valid_pixel;
  logic [7:0]  sat_r, sat_g, sat_b;

  logic [7:0]  ram0 [256];
  logic [7:0]  ram1 [256];

  int checks = 0;
  int errors = 0;

  int span_y   [6] = '{80, 120, 160, 78, 162, 81};
  bit span_hit [6] = '{1, 1, 1, 0, 0, 1};
  int b2b_x    [5] = '{256, 257, 258, 258, 259};
  bit b2b_v    [5] = '{1, 1, 0, 1, 1};
  bit b2b_hit  [5] = '{0, 0, 0, 1, 1};

  wave_display_mc #(
    .CH_COLOR ({C1, C0})
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .x            (x),
    .y            (y),
    .valid        (valid),
    .read_index   (read_index),
    .read_value   (read_value),
    .grid_en      (grid_en),
    .read_address (read_address),
    .pixel_valid  (pixel_valid),
    .valid_pixel  (valid_pixel),
    .r            (r),
    .g            (g),
    .b            (b)
  );

  wave_display_mc #(
    .VSCALE_SHIFT (0),
    .CH_COLOR     ({C1, C0})
  ) dut_sat (
    .clk          (clk),
    .reset        (reset),
    .x            (x),
    .y            (y),
    .valid        (valid),
    .read_index   (read_index),
    .read_value   (read_value),
    .grid_en      (grid_en),
    .read_address (sat_address),
    .pixel_valid  (sat_pixel_valid),
    .valid_pixel  (sat_valid_pixel),
    .r            (sat_r),
    .g            (sat_g),
    .b            (sat_b)
  );

  // Clock
  always #5 clk = ~clk;

  // Sample RAMs with one cycle of read latency (bank bit ignored).
  always @(posedge clk) read_value <= {ram1[read_address[7:0]], ram0[read_address[7:0]]};

  // Drive one valid pixel, then idle until its outputs are visible.
  task automatic drive_pixel(input int px, input int py);
    x = 11'(px);
    y = 10'(py);
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    if (pixel_valid !== 1'b0) begin errors++; $display("FAIL reset_pv got=%0b exp=0", pixel_valid); end
    checks++;
    if (valid_pixel !== 1'b0) begin errors++; $display("FAIL reset_vp got=%0b exp=0", valid_pixel); end
    checks++;
    if ({r, g, b} !== 24'h0) begin errors++; $display("FAIL reset_rgb got=%h exp=000000", {r, g, b}); end
    checks++;
    if (read_address !== 9'd0) begin errors++; $display("FAIL reset_addr got=%0d exp=0", read_address); end
    checks++;
  endtask

  task automatic test_latency;
    ram0[0] = 8'd64;
    x = 11'd256; y = 10'd128; valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      valid = 1'b0;
      if (pixel_valid !== (k == 3)) begin
        errors++; $display("FAIL latency_pv cycle=%0d got=%0b exp=%0b", k, pixel_valid, (k == 3));
      end
      checks++;
      if (k == 3) begin
        if (valid_pixel !== 1'b1) begin errors++; $display("FAIL latency_vp got=%0b exp=1", valid_pixel); end
        checks++;
        if ({r, g, b} !== C0) begin errors++; $display("FAIL latency_rgb got=%h exp=%h", {r, g, b}, C0); end
        checks++;
      end
    end
    ram0[0] = 8'd200;
    drive_pixel(256, 128);
    if (pixel_valid !== 1'b1) begin errors++; $display("FAIL raw200_pv got=%0b exp=1", pixel_valid); end
    checks++;
    if (valid_pixel !== 1'b0) begin errors++; $display("FAIL raw200_vp got=%0b exp=0", valid_pixel); end
    checks++;
    if ({r, g, b} !== 24'h0) begin errors++; $display("FAIL raw200_rgb got=%h exp=000000", {r, g, b}); end
    checks++;
    drive_pixel(256, 264);
    if (valid_pixel !== 1'b1) begin errors++; $display("FAIL raw200_row132 got=%0b exp=1", valid_pixel); end
    checks++;
  endtask

  task automatic test_bank_latch;
    read_index = 1'b1;
    x = 11'd300; y = 10'd10; valid = 1'b1; #1;
    if (read_address !== 9'd22) begin errors++; $display("FAIL bank_mid got=%0d exp=22", read_address); end
    checks++;
    @(posedge clk); #1;
    if (read_address !== 9'd22) begin errors++; $display("FAIL bank_hold got=%0d exp=22", read_address); end
    checks++;
    x = 11'd0; y = 10'd0; #1;
    if (read_address !== 9'd0) begin errors++; $display("FAIL bank_origin got=%0d exp=0", read_address); end
    checks++;
    @(posedge clk); #1;
    x = 11'd300; y = 10'd0; read_index = 1'b0; #1;
    if (read_address !== 9'd278) begin errors++; $display("FAIL bank_new got=%0d exp=278", read_address); end
    checks++;
    @(posedge clk); #1;
    x = 11'd302; y = 10'd1; #1;
    if (read_address !== 9'd279) begin errors++; $display("FAIL bank_frame got=%0d exp=279", read_address); end
    checks++;
    x = 11'd100; #1;
    if (read_address !== 9'd256) begin errors++; $display("FAIL bank_outside got=%0d exp=256", read_address); end
    checks++;
    x = 11'd0; y = 10'd0;
    @(posedge clk); #1;
    valid = 1'b0; read_index = 1'b1; x = 11'd300; #1;
    if (read_address !== 9'd22) begin errors++; $display("FAIL bank_back0 got=%0d exp=22", read_address); end
    checks++;
    x = 11'd0; y = 10'd0;
    @(posedge clk); #1;
    x = 11'd300; #1;
    if (read_address !== 9'd22) begin errors++; $display("FAIL bank_novalid got=%0d exp=22", read_address); end
    checks++;
    read_index = 1'b0;
  endtask

  task automatic test_span;
    ram0[10] = 8'd16;
    ram0[11] = 8'd96;
    for (int i = 0; i < 6; i++) begin
      drive_pixel(276, 0);
      drive_pixel(278, span_y[i]);
      if (valid_pixel !== span_hit[i]) begin
        errors++; $display("FAIL span_vp y=%0d got=%0b exp=%0b", span_y[i], valid_pixel, span_hit[i]);
      end
      checks++;
      if ({r, g, b} !== (span_hit[i] ? C0 : 24'h0)) begin
        errors++; $display("FAIL span_rgb y=%0d got=%h", span_y[i], {r, g, b});
      end
      checks++;
    end
    ram0[0] = 8'd16;
    drive_pixel(256, 80);
    if (valid_pixel !== 1'b1) begin errors++; $display("FAIL line_start_row got=%0b exp=1", valid_pixel); end
    checks++;
    drive_pixel(256, 82);
    if (valid_pixel !== 1'b0) begin errors++; $display("FAIL line_start_above got=%0b exp=0", valid_pixel); end
    checks++;
    drive_pixel(257, 80);
    if (valid_pixel !== 1'b1) begin errors++; $display("FAIL line_start_zoom got=%0b exp=1", valid_pixel); end
    checks++;
  endtask

  task automatic test_priority;
    grid_en = 1'b1;
    ram0[0] = 8'd100; ram1[0] = 8'd100;
    drive_pixel(256, 164);
    if ({r, g, b} !== C0) begin errors++; $display("FAIL prio_both got=%h exp=%h", {r, g, b}, C0); end
    checks++;
    ram0[0] = 8'd0;
    drive_pixel(256, 164);
    if ({r, g, b} !== C1) begin errors++; $display("FAIL prio_ch1 got=%h exp=%h", {r, g, b}, C1); end
    checks++;
    ram1[0] = 8'd0;
    drive_pixel(256, 200);
    drive_pixel(320, 200);
    if ({r, g, b} !== GRID) begin errors++; $display("FAIL grid_x got=%h exp=%h", {r, g, b}, GRID); end
    checks++;
    if (valid_pixel !== 1'b0) begin errors++; $display("FAIL grid_vp got=%0b exp=0", valid_pixel); end
    checks++;
    drive_pixel(322, 201);
    if ({r, g, b} !== 24'h0) begin errors++; $display("FAIL grid_off got=%h exp=000000", {r, g, b}); end
    checks++;
    drive_pixel(322, 192);
    if ({r, g, b} !== GRID) begin errors++; $display("FAIL grid_y got=%h exp=%h", {r, g, b}, GRID); end
    checks++;
    drive_pixel(100, 0);
    if ({r, g, b} !== 24'h0) begin errors++; $display("FAIL grid_outside got=%h exp=000000", {r, g, b}); end
    checks++;
    if (pixel_valid !== 1'b1) begin errors++; $display("FAIL outside_pv got=%0b exp=1", pixel_valid); end
    checks++;
    grid_en = 1'b0;
    drive_pixel(320, 200);
    if ({r, g, b} !== 24'h0) begin errors++; $display("FAIL grid_disabled got=%h exp=000000", {r, g, b}); end
    checks++;
  endtask

  task automatic test_saturation;
    ram0[0] = 8'd255; ram1[0] = 8'd0;
    drive_pixel(256, 510);
    if (sat_valid_pixel !== 1'b1) begin errors++; $display("FAIL sat_top got=%0b exp=1", sat_valid_pixel); end
    checks++;
    if (valid_pixel !== 1'b0) begin errors++; $display("FAIL scaled_top got=%0b exp=0", valid_pixel); end
    checks++;
    drive_pixel(256, 62);
    if (sat_valid_pixel !== 1'b0) begin errors++; $display("FAIL sat_nowrap got=%0b exp=0", sat_valid_pixel); end
    checks++;
    drive_pixel(256, 318);
    if (valid_pixel !== 1'b1) begin errors++; $display("FAIL scaled_159 got=%0b exp=1", valid_pixel); end
    checks++;
  endtask

  task automatic test_reset_mid_line;
    ram0[72] = 8'd200;
    read_index = 1'b1; x = 11'd0; y = 10'd0; valid = 1'b1;
    @(posedge clk); #1;
    drive_pixel(400, 264);
    if (valid_pixel !== 1'b1) begin errors++; $display("FAIL pre_reset_vp got=%0b exp=1", valid_pixel); end
    checks++;
    reset = 1'b1; #1;
    if (pixel_valid !== 1'b0) begin errors++; $display("FAIL midreset_pv got=%0b exp=0", pixel_valid); end
    checks++;
    if ({r, g, b} !== 24'h0) begin errors++; $display("FAIL midreset_rgb got=%h exp=000000", {r, g, b}); end
    checks++;
    if (read_address !== 9'd72) begin errors++; $display("FAIL midreset_addr got=%0d exp=72", read_address); end
    checks++;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    ram0[0] = 8'd16;
    drive_pixel(256, 40);
    if (valid_pixel !== 1'b0) begin errors++; $display("FAIL stale_span got=%0b exp=0", valid_pixel); end
    checks++;
    drive_pixel(256, 80);
    if ({r, g, b} !== C0) begin errors++; $display("FAIL post_reset_rgb got=%h exp=%h", {r, g, b}, C0); end
    checks++;
    read_index = 1'b0;
  endtask

  task automatic test_back_to_back;
    ram0[0] = 8'd16; ram0[1] = 8'd96; ram1[0] = 8'd0; ram1[1] = 8'd0;
    for (int c = 0; c < 7; c++) begin
      if (c < 5) begin
        x = 11'(b2b_x[c]); y = 10'd120; valid = b2b_v[c];
      end else begin
        valid = 1'b0;
      end
      @(posedge clk); #1;
      if (c >= 2) begin
        if (pixel_valid !== b2b_v[c-2]) begin
          errors++; $display("FAIL b2b_pv idx=%0d got=%0b exp=%0b", c - 2, pixel_valid, b2b_v[c-2]);
        end
        checks++;
        if (valid_pixel !== b2b_hit[c-2]) begin
          errors++; $display("FAIL b2b_vp idx=%0d got=%0b exp=%0b", c - 2, valid_pixel, b2b_hit[c-2]);
        end
        checks++;
      end
    end
  endtask

  initial begin
    reset = 1'b1; x = '0; y = '0; valid = 1'b0; read_index = 1'b0; grid_en = 1'b0;
    for (int i = 0; i < 256; i++) begin
      ram0[i] = 8'd0;
      ram1[i] = 8'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_latency();
    test_bank_latch();
    test_span();
    test_priority();
    test_saturation();
    test_reset_mid_line();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end

endmodule
